// File: rtl/multicycle_ctrl_v2.sv
// rtl/multicycle_ctrl_v2.sv - multicycle RV32I-subset control FSM with wait states and instret
// Optional trap state enabled by defining CTRL_TRAP_EN.
module multicycle_ctrl_v2 #(
    parameter int              OP_W   = 7,
    parameter int              CNT_W  = 32,
    parameter logic [OP_W-1:0] OPC_R  = 7'b0110011,
    parameter logic [OP_W-1:0] OPC_I  = 7'b0010011,
    parameter logic [OP_W-1:0] OPC_LW = 7'b0000011,
    parameter logic [OP_W-1:0] OPC_SW = 7'b0100011,
    parameter logic [OP_W-1:0] OPC_BR = 7'b1100011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  Op,
    input  logic             mem_ready,
    output logic [3:0]       state,
    output logic             RegDst,
    output logic             PCWriteCond,
    output logic             PCWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRwrite,
    output logic             PCSource,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_EXEC_IMM  = 4'd9,
        S_TRAP      = 4'd11
    } state_t;

    state_t cur, nxt;

    assign state = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= S_FETCH;
        end else begin
            cur <= nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        nxt         = S_FETCH;
        RegDst      = 1'b0;
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRwrite     = 1'b0;
        PCSource    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        retire      = 1'b0;
        illegal     = 1'b0;

        case (cur)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRwrite = mem_ready;
                PCWrite = mem_ready;
                nxt     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                if (Op == OPC_R) begin
                    nxt = S_EXECUTE;
                end else if (Op == OPC_I) begin
                    nxt = S_EXEC_IMM;
                end else if (Op == OPC_LW || Op == OPC_SW) begin
                    nxt = S_MEM_ADDR;
                end else if (Op == OPC_BR) begin
                    nxt = S_BRANCH;
                end else begin
                    illegal = 1'b1;
`ifdef CTRL_TRAP_EN
                    nxt = S_TRAP;
`else
                    nxt = S_FETCH;
`endif
                end
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                // Op re-checked here; anything other than LW/SW abandons the access
                if (Op == OPC_LW) begin
                    nxt = S_MEM_READ;
                end else if (Op == OPC_SW) begin
                    nxt = S_MEM_WRITE;
                end else begin
                    nxt = S_FETCH;
                end
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                nxt     = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                nxt      = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                retire   = mem_ready;
                nxt      = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                nxt     = S_ALU_WB;
            end
            S_ALU_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
                nxt      = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                retire      = 1'b1;
                nxt         = S_FETCH;
            end
            S_EXEC_IMM: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
                nxt     = S_ALU_WB;
            end
`ifdef CTRL_TRAP_EN
            S_TRAP: begin
                illegal = 1'b1;
                nxt     = S_TRAP;
            end
`endif
            default: begin
                nxt = S_FETCH;
            end
        endcase

        // Reset forces every output quiet, including an in-flight retire
        if (rst) begin
            RegDst      = 1'b0;
            PCWriteCond = 1'b0;
            PCWrite     = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            IRwrite     = 1'b0;
            PCSource    = 1'b0;
            ALUSrcA     = 1'b0;
            RegWrite    = 1'b0;
            ALUOp       = 2'b00;
            ALUSrcB     = 2'b00;
            retire      = 1'b0;
            illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// tb/tb_multicycle_ctrl_v2.sv - table-driven scoreboard bench for multicycle_ctrl_v2
module tb_multicycle_ctrl_v2;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic       mem_ready;
    logic [3:0] state;
    logic       RegDst, PCWriteCond, PCWrite, IorD, MemRead, MemWrite;
    logic       MemtoReg, IRwrite, PCSource, ALUSrcA, RegWrite;
    logic [1:0] ALUOp, ALUSrcB;
    logic       retire;
    logic [3:0] instret;
    logic       illegal;

    always #5 clk = ~clk;

    multicycle_ctrl_v2 #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .Op(op), .mem_ready(mem_ready), .state(state),
        .RegDst(RegDst), .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRwrite(IRwrite),
        .PCSource(PCSource), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .retire(retire), .instret(instret), .illegal(illegal)
    );

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       mr;
        logic [3:0] st;
        logic       ret;
        logic       ill;
    } vec_t;

    typedef struct {
        logic [3:0]  st;
        logic [14:0] ctrl;
        logic        ret;
        logic        ill;
        logic [3:0]  cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   row = 0;
    logic [3:0] model_cnt = 4'd0;

    wire [14:0] ctrl_act = {RegDst, PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
                            IRwrite, PCSource, ALUSrcA, RegWrite, ALUOp, ALUSrcB};

    // Expected control word per state, same packing as ctrl_act
    function automatic logic [14:0] ctrl_model(input logic [3:0] s, input logic mr);
        logic regdst, pcwc, pcw, iord, mrd, mwr, m2r, irw, pcs, asa, rw;
        logic [1:0] aop, asb;
        {regdst, pcwc, pcw, iord, mrd, mwr, m2r, irw, pcs, asa, rw} = '0;
        aop = 2'b00;
        asb = 2'b00;
        case (s)
            4'd0: begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd1: asb = 2'b11;
            4'd2: begin asa = 1; asb = 2'b10; end
            4'd3: begin mrd = 1; iord = 1; end
            4'd4: begin rw = 1; m2r = 1; end
            4'd5: begin mwr = 1; iord = 1; end
            4'd6: begin asa = 1; aop = 2'b10; end
            4'd7: begin rw = 1; regdst = 1; end
            4'd8: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 1; end
            4'd9: begin asa = 1; asb = 2'b10; aop = 2'b11; end
            default: ;
        endcase
        return {regdst, pcwc, pcw, iord, mrd, mwr, m2r, irw, pcs, asa, rw, aop, asb};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [6:0] o, input logic m,
                       input logic [3:0] s, input logic rt, input logic il);
        vec_t v;
        v.rst = r; v.op = o; v.mr = m; v.st = s; v.ret = rt; v.ill = il;
        vecs.push_back(v);
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rst = v.rst;
        op = v.op;
        mem_ready = v.mr;
        e.st   = v.st;
        e.ctrl = v.rst ? 15'd0 : ctrl_model(v.st, v.mr);
        e.ret  = v.ret;
        e.ill  = v.ill;
        e.cnt  = model_cnt;
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        check("state",   16'(state),    16'(g.st));
        check("ctrl",    16'(ctrl_act), 16'(g.ctrl));
        check("retire",  16'(retire),   16'(g.ret));
        check("illegal", 16'(illegal),  16'(g.ill));
        check("instret", 16'(instret),  16'(g.cnt));
        if (v.rst) model_cnt = 4'd0;
        else if (v.ret) model_cnt = model_cnt + 4'd1;
        row++;
    endtask

    initial begin
        rst = 1'b1;
        op = 7'd0;
        mem_ready = 1'b1;

        for (int k = 0; k < 5; k++) add(1, R, 1, 0, 0, 0);
        // R-type
        add(0, R, 1, 0, 0, 0); add(0, R, 1, 1, 0, 0); add(0, R, 1, 6, 0, 0); add(0, R, 1, 7, 1, 0);
        // LW with two wait cycles in MEM_READ
        add(0, LW, 1, 0, 0, 0); add(0, LW, 1, 1, 0, 0); add(0, LW, 1, 2, 0, 0);
        add(0, LW, 0, 3, 0, 0); add(0, LW, 0, 3, 0, 0); add(0, LW, 1, 3, 0, 0); add(0, LW, 1, 4, 1, 0);
        // SW with FETCH stall and one MEM_WRITE wait
        add(0, SW, 0, 0, 0, 0); add(0, SW, 0, 0, 0, 0); add(0, SW, 0, 0, 0, 0); add(0, SW, 1, 0, 0, 0);
        add(0, SW, 1, 1, 0, 0); add(0, SW, 1, 2, 0, 0); add(0, SW, 0, 5, 0, 0); add(0, SW, 1, 5, 1, 0);
        // Branch then I-type back to back
        add(0, BR, 1, 0, 0, 0); add(0, BR, 1, 1, 0, 0); add(0, BR, 1, 8, 1, 0);
        add(0, I, 1, 0, 0, 0); add(0, I, 1, 1, 0, 0); add(0, I, 1, 9, 0, 0); add(0, I, 1, 7, 1, 0);
        // Op changes outside DECODE/MEM_ADDR are ignored
        add(0, R, 1, 0, 0, 0); add(0, R, 1, 1, 0, 0); add(0, LW, 1, 6, 0, 0); add(0, SW, 1, 7, 1, 0);
        // Illegal opcode
        add(0, BAD, 1, 0, 0, 0); add(0, BAD, 1, 1, 0, 1);
`ifdef CTRL_TRAP_EN
        add(0, 7'd0, 1, 11, 0, 1); add(0, R, 1, 11, 0, 1); add(0, R, 0, 11, 0, 1);
        add(1, 7'd0, 1, 11, 0, 0);
`else
        add(0, 7'd0, 0, 0, 0, 0);
`endif
        // Reset mid-LW
        add(0, LW, 1, 0, 0, 0); add(0, LW, 1, 1, 0, 0); add(0, LW, 1, 2, 0, 0);
        add(0, LW, 0, 3, 0, 0); add(1, LW, 1, 3, 0, 0);

        @(posedge clk);
        foreach (vecs[k]) step(vecs[k]);

        // 16 branches wrap the 4-bit counter back to 0
        for (int k = 0; k < 16; k++) begin
            vec_t v;
            v.rst = 0; v.op = BR; v.mr = 1; v.ill = 0;
            v.st = 4'd0; v.ret = 0; step(v);
            v.st = 4'd1; step(v);
            v.st = 4'd8; v.ret = 1; step(v);
        end
        begin
            vec_t v;
            v.rst = 0; v.op = R; v.mr = 0; v.st = 4'd0; v.ret = 0; v.ill = 0;
            step(v);
        end
        check("instret_wrap", 16'(instret), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_v2.md
Name: multicycle_ctrl_v2

Overview:
- Second-generation multicycle CPU control FSM for the RV32I-subset datapath.
- Extends the original controller in four ways:
  - adds I-type ALU instructions;
  - adds a memory wait-state handshake (mem_ready) on every memory state;
  - makes the opcode map a set of parameters;
  - adds an instructions-retired counter.
- Drives the datapath muxes and enables directly.
- Sits between the instruction register (Op field) and the datapath/memory interface.

Parameters:
- OP_W, 7, opcode field width.
- CNT_W, 32, width of instret counter.
- OPC_R, 7'b0110011, R-type opcode.
- OPC_I, 7'b0010011, I-type ALU opcode.
- OPC_LW, 7'b0000011, load opcode.
- OPC_SW, 7'b0100011, store opcode.
- OPC_BR, 7'b1100011, branch opcode.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- Op  in  OP_W  opcode from instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- state  out  4  current FSM state encoding.
- RegDst, PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRwrite, PCSource, ALUSrcA, RegWrite  out  1 each  datapath controls.
- ALUOp  out  2  00 add, 01 sub/compare, 10 R-funct, 11 I-funct.
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 imm, 11 branch offset.
- retire  out  1  one-cycle pulse when an instruction completes.
- instret  out  CNT_W  retired-instruction count.
- illegal  out  1  unknown opcode decoded.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset behaviour:
  - state=0 (FETCH), instret=0, illegal=0.
  - While rst=1, all control outputs and retire are 0.
  - Reset mid-instruction aborts it: next state is FETCH and no retire pulse is issued.
- Control outputs are Moore-style decodes of state, except where gated by mem_ready. Any control not listed for a state is 0.
- State encodings and actions:
  - 0 FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0. IRwrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; on mem_ready=1 goes to DECODE.
  - 1 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Op is sampled here:
    - R -> 6; I -> 9; LW or SW -> 2; BR -> 8; other -> illegal path.
  - 2 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> 3; SW -> 5.
  - 3 MEM_READ: MemRead=1, IorD=1. Waits for mem_ready, then -> 4.
  - 4 MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Retires; -> 0.
  - 5 MEM_WRITE: MemWrite=1, IorD=1. Waits for mem_ready; retires and -> 0 on the mem_ready cycle. MemWrite stays high through the wait.
  - 6 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> 7.
  - 7 ALU_WB: RegWrite=1, RegDst=1, MemtoReg=0. Retires; -> 0.
  - 8 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1. Retires; -> 0.
  - 9 EXEC_IMM: ALUSrcA=1, ALUSrcB=10, ALUOp=11. -> 7.
  - 11 TRAP: defined under Optional Feature.
  - Encodings 10 and 12-15 are unreachable and recover to FETCH on the next cycle with all controls 0.
- Op is used only in the DECODE and MEM_ADDR cycles. Changes to Op in other cycles have no effect.
- Retire and counter:
  - retire is a combinational pulse in the retiring cycle.
  - instret increments on the following edge.
  - instret wraps from 2^CNT_W-1 to 0 with no flag.
- Cycle counts with mem_ready held at 1: R/I = 4, LW = 5, SW = 4, BR = 3. Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle.

Optional Feature:
- Macro: CTRL_TRAP_EN.
- Defined:
  - An illegal opcode in DECODE goes to state 11 TRAP.
  - In TRAP, illegal=1, all controls are 0, and there is no retire.
  - The FSM holds in TRAP until rst.
- Undefined:
  - An illegal opcode in DECODE goes straight to FETCH as a NOP.
  - illegal pulses high for that DECODE cycle only; there is no retire.
  - State 11 is unreachable.

Test Plan:
- R-type: rst for 5 cycles, release, Op=0110011, mem_ready=1 -> state sequence 0,1,6,7,0. In state 7: RegWrite=1, RegDst=1, ALUOp=10. One retire pulse; instret=1.
- LW with wait: Op=0000011, mem_ready=0 for the first 2 cycles of MEM_READ -> state sequence 0,1,2,3,3,3,4,0. MemRead=IorD=1 throughout state 3; MemtoReg=1 in state 4.
- SW and FETCH stall: mem_ready=0 for 3 cycles in FETCH -> IRwrite and PCWrite stay 0 until mem_ready=1. Then 1,2,5,0 follows with MemWrite=1 only in state 5.
- Branch then I-type back-to-back: Op=1100011 then 0010011 -> 0,1,8 with PCWriteCond=1, ALUOp=01 and PCSource=1 in state 8, then 0,1,9,7. instret goes +2.
- Illegal Op=7'b1111111:
  - With CTRL_TRAP_EN: state holds at 11, illegal=1, until rst.
  - Without it: state returns to 0 after DECODE with a 1-cycle illegal pulse; instret unchanged.
- Reset mid-LW (rst asserted in state 3) -> next state 0, controls 0 while rst=1, instret cleared. With CNT_W=4, 16 retires -> instret wraps to 0.
